// File: rtl/retire_trace_monitor_pkg.sv
// Shared CPU package: instruction-type codes, monitor FSM state encoding and
// small helpers used by the retire trace monitor.
//   No ports (package).
package retire_trace_monitor_pkg;

    localparam int unsigned INSN_TYPE_W = 7;

    // Writeback instruction-type codes
    localparam logic [6:0] INSN_NOP    = 7'd0;
    localparam logic [6:0] INSN_ALU    = 7'd1;
    localparam logic [6:0] INSN_LOAD   = 7'd2;
    localparam logic [6:0] INSN_STORE  = 7'd3;
    localparam logic [6:0] INSN_BRANCH = 7'd4;
    localparam logic [6:0] INSN_JUMP   = 7'd5;
    localparam logic [6:0] INSN_SYSTEM = 7'd6;
    localparam logic [6:0] INSN_HALT   = 7'd7;

    // Monitor FSM: RUN until halt/timeout, then STOPPED until reset
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } mon_state_e;

    // 32-bit increment that sticks at all-ones
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            sat_inc32 = v;
        end else begin
            sat_inc32 = v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/retire_trace_monitor_trace_ring.sv
// Circular trace buffer with overwrite-on-full push and a registered pop port.
//   clk, rst        : clock, asynchronous active-high reset (pointers/flags only)
//   push, push_data : append one entry; when full the oldest entry is dropped
//   pop             : remove oldest entry (ignored when empty)
//   occ             : entries currently held (0..DEPTH)
//   overflow        : sticky, set when a push dropped an entry
//   rd_valid/rd_data: popped entry, one cycle after pop; rd_data holds otherwise
module retire_trace_monitor_trace_ring #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   occ,
    output logic                     overflow,
    output logic                     rd_valid,
    output logic [W-1:0]             rd_data
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned OCC_W = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic          full_s;
    logic          empty_s;

    assign full_s  = (occ == OCC_W'(DEPTH));
    assign empty_s = (occ == OCC_W'(0));

    // Trace storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy, overflow flag and the registered read port.
    // DEPTH is a power of two, so pointer wrap is plain binary rollover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            occ      <= OCC_W'(0);
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= W'(0);
        end else begin
            rd_valid <= 1'b0;
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
                if (full_s) begin
                    // Oldest entry is the one being overwritten: skip past it
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                    overflow <= 1'b1;
                end else begin
                    occ <= occ + OCC_W'(1);
                end
            end else if (pop && !empty_s) begin
                rd_data  <= mem_r[rd_ptr_r];
                rd_valid <= 1'b1;
                rd_ptr_r <= rd_ptr_r + AW'(1);
                occ      <= occ - OCC_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

endmodule

// File: rtl/retire_trace_monitor.sv
// Retire trace monitor: counts cycles and retirements while the program runs,
// records retired PCs in a trace ring, and stops on a halt instruction or a
// cycle limit. Once stopped the trace can be popped oldest-first.
//   clk, rst            : clock, asynchronous active-high reset
//   wb_v/wb_type/wb_pc  : retiring instruction from writeback
//   rd_req              : pop one trace entry (only honoured when stopped)
//   halted, timeout     : stop cause (halt wins if both happen together)
//   overflow            : sticky, trace entry overwritten
//   cycle_cnt/retire_cnt: saturating 32-bit counters, frozen once stopped
//   occ                 : trace entries held
//   rd_valid/rd_data    : popped PC, latency 1
module retire_trace_monitor
    import retire_trace_monitor_pkg::*;
#(
    parameter int unsigned       PC_W       = 32,
    parameter int unsigned       TYPE_W     = 7,
    parameter logic [TYPE_W-1:0] HALT_TYPE  = TYPE_W'(INSN_HALT),
    parameter logic [31:0]       MAX_CYCLES = 32'd500,
    parameter int unsigned       DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_v,
    input  logic [TYPE_W-1:0]      wb_type,
    input  logic [PC_W-1:0]        wb_pc,
    input  logic                   rd_req,
    output logic                   halted,
    output logic                   timeout,
    output logic                   overflow,
    output logic [31:0]            cycle_cnt,
    output logic [31:0]            retire_cnt,
    output logic [$clog2(DEPTH):0] occ,
    output logic                   rd_valid,
    output logic [PC_W-1:0]        rd_data
);
    mon_state_e state_r;
    mon_state_e state_nxt_s;
    logic       halt_hit_s;
    logic       limit_hit_s;
    logic       push_s;
    logic       pop_s;

    // Next-state decode plus per-cycle push/pop/stop controls
    always_comb begin
        state_nxt_s = state_r;
        halt_hit_s  = 1'b0;
        limit_hit_s = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_RUN: begin
                push_s      = wb_v;
                halt_hit_s  = wb_v && (wb_type == HALT_TYPE);
                limit_hit_s = (cycle_cnt == (MAX_CYCLES - 32'd1));
                if (halt_hit_s || limit_hit_s) begin
                    state_nxt_s = ST_STOPPED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STOPPED: begin
                pop_s       = rd_req;
                state_nxt_s = ST_STOPPED;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters and stop-cause flags; a halt in the limit cycle reports halt only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= 32'd0;
            retire_cnt <= 32'd0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (state_r == ST_RUN) begin
                cycle_cnt <= sat_inc32(cycle_cnt);
                if (wb_v) begin
                    retire_cnt <= sat_inc32(retire_cnt);
                end
            end
            if (halt_hit_s) begin
                halted <= 1'b1;
            end else if (limit_hit_s) begin
                timeout <= 1'b1;
            end
        end
    end

    retire_trace_monitor_trace_ring #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_trace_ring (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (wb_pc),
        .pop       (pop_s),
        .occ       (occ),
        .overflow  (overflow),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

endmodule

// File: doc/retire_trace_monitor.md
RETIRE_TRACE_MONITOR -- requirements
Module: retire_trace_monitor

Interface
REQ-001 SHALL have parameter PC_W, default 32, retired-PC width.
REQ-002 SHALL have parameter TYPE_W, default 7, writeback instruction-type width.
REQ-003 SHALL have parameter HALT_TYPE, default 7, type code that ends the program.
REQ-004 SHALL have parameter MAX_CYCLES, default 500, cycle limit before timeout (legal 2..2^32-1).
REQ-005 SHALL have parameter DEPTH, default 16, trace-buffer entries (power of two, >=2).
REQ-006 CLK  in  1  single clock, all state updates on its rising edge.
REQ-007 RST  in  1  reset, asynchronous, active-high.
REQ-008 WB_V  in  1  writeback stage holds a valid retiring instruction.
REQ-009 WB_TYPE  in  TYPE_W  type of retiring instruction.
REQ-010 WB_PC  in  PC_W  PC of retiring instruction.
REQ-011 RD_REQ  in  1  pop one trace entry (honoured only in STOPPED).
REQ-012 HALTED  out  1  program stopped on HALT_TYPE.
REQ-013 TIMEOUT  out  1  program stopped on cycle limit.
REQ-014 OVERFLOW  out  1  sticky, at least one trace entry overwritten.
REQ-015 CYCLE_CNT  out  32  cycles spent in RUN.
REQ-016 RETIRE_CNT  out  32  valid retirements counted.
REQ-017 OCC  out  clog2(DEPTH)+1  trace entries held.
REQ-018 RD_VALID  out  1  RD_DATA valid this cycle.
REQ-019 RD_DATA  out  PC_W  popped PC, oldest first.

Function
REQ-020 SHALL implement FSM RUN -> STOPPED; no exit from STOPPED except RST.
REQ-021 In RUN, SHALL increment CYCLE_CNT every cycle, saturating at all-ones.
REQ-022 In RUN, each cycle with WB_V=1 SHALL increment RETIRE_CNT (saturating) and push WB_PC.
REQ-023 Push with OCC=DEPTH SHALL overwrite the oldest entry, keep OCC=DEPTH, set OVERFLOW.
REQ-024 WB_V=1 with WB_TYPE=HALT_TYPE in RUN SHALL be counted and pushed, then HALTED=1 and state=STOPPED from the next cycle.
REQ-025 When CYCLE_CNT=MAX_CYCLES-1 in RUN with no halt that cycle, SHALL set TIMEOUT=1 and enter STOPPED next cycle (CYCLE_CNT=MAX_CYCLES).
REQ-026 Halt and timeout in the same cycle SHALL resolve to HALTED=1, TIMEOUT=0.
REQ-027 In STOPPED, CYCLE_CNT, RETIRE_CNT and pushes SHALL freeze; WB_* ignored.
REQ-028 In RUN, RD_REQ SHALL be ignored and RD_VALID held 0.
REQ-029 In STOPPED, RD_REQ=1 with OCC>0 SHALL give RD_VALID=1 and oldest PC on RD_DATA the next cycle, decrementing OCC by 1 (latency 1, one pop per cycle, back-to-back allowed).
REQ-030 RD_REQ=1 with OCC=0 SHALL be ignored (RD_VALID=0 next cycle, no pointer change).
REQ-031 RD_DATA SHALL hold its last value when RD_VALID=0.
REQ-032 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 RST=1 SHALL immediately force state RUN, HALTED=0, TIMEOUT=0, OVERFLOW=0, CYCLE_CNT=0, RETIRE_CNT=0, OCC=0, pointers=0, RD_VALID=0, RD_DATA=0.
REQ-034 RST asserted mid-run or mid-readout SHALL discard all trace contents; first counted cycle is the first rising edge after RST deasserts.
REQ-035 Trace-buffer storage SHALL need no reset.

Structure
REQ-036 HALT_TYPE code and FSM state encoding SHALL live in the shared CPU package alongside the instruction-type constants.
REQ-037 Trace storage SHALL be a sub-module trace_ring (circular buffer, overwrite-on-full, pop port); counters and FSM in the top.
REQ-038 Block SHALL be synthesizable and instantiable by both the CPU testbench and an on-chip debug wrapper.

Verification
REQ-039 Retire PCs 0x0,0x4,0x8 then HALT_TYPE at 0xC on cycles 1-4 -> HALTED=1 on cycle 5, RETIRE_CNT=4, OCC=4, pops return 0x0,0x4,0x8,0xC.
REQ-040 MAX_CYCLES=10, WB_V=0 throughout -> TIMEOUT=1, CYCLE_CNT=10, OCC=0, RD_REQ gives RD_VALID=0.
REQ-041 DEPTH=4, retire PCs 1..6 then halt PC 7 -> OVERFLOW=1, OCC=4, pops return 4,5,6,7, fifth RD_REQ gives RD_VALID=0.
REQ-042 MAX_CYCLES=5, halt retires in cycle where CYCLE_CNT=4 -> HALTED=1, TIMEOUT=0.
REQ-043 RST pulsed for 1 cycle after 3 retirements, then halt at PC 0x20 -> RETIRE_CNT=1, OCC=1, pop returns 0x20.
REQ-044 RD_REQ held high during RUN with retirements -> RD_VALID stays 0 and OCC unaffected until STOPPED.
